m3_phasegatedriver: RTL and testbench

//  Downstream of the motor speed/step calculator. Converts the 12-step commutation index and an 8-bit power

---
 rtl/m3_phasegatedriver.sv | 155 +++++++++++++++
 tb/tb_m3_phasegatedriver.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/m3_phasegatedriver.sv
`timescale 1ns/1ps
// m3 phase gate driver: 12-step commutation index plus edge-aligned PWM to six half-bridge gates,
// with one dead-time FSM per leg so a leg's high and low switches never conduct together.
module m3_phasegatedriver #(
  parameter int PWM_BITS  = 8,
  parameter int DEAD_CLKS = 2
) (
  input  logic                clkI,
  input  logic                nRstI,
  input  logic [3:0]          m3stepI,
  input  logic [PWM_BITS-1:0] m3powerI,
  input  logic                m3invRotateI,
  input  logic                m3forceStopI,
  output logic                m3uHo,
  output logic                m3uLo,
  output logic                m3vHo,
  output logic                m3vLo,
  output logic                m3wHo,
  output logic                m3wLo,
  output logic                m3activeO
);

  typedef enum logic [1:0] {
    LEG_OFF  = 2'd0,
    LEG_HI   = 2'd1,
    LEG_LO   = 2'd2,
    LEG_DEAD = 2'd3
  } leg_state_t;

  localparam logic [3:0] DEAD_INIT = 4'(DEAD_CLKS - 1);

  // Leg index 0=U, 1=V, 2=W; reverse rotation swaps the V and W roles.
  function automatic logic [2:0] phase_mask(input logic [1:0] leg, input logic inv);
    case (leg)
      2'd0:    phase_mask = 3'b001;
      2'd1:    phase_mask = inv ? 3'b100 : 3'b010;
      default: phase_mask = inv ? 3'b010 : 3'b100;
    endcase
  endfunction

  logic [PWM_BITS-1:0] r_cnt;
  logic [PWM_BITS-1:0] r_duty;
  logic                w_wrap;
  logic                w_pwmOn;

  assign w_wrap  = (r_cnt == {PWM_BITS{1'b1}});
  assign w_pwmOn = (r_cnt < r_duty);

  // Duty only reloads as the carrier wraps, so a period never sees a mid-cycle duty edit.
  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      r_cnt  <= '0;
      r_duty <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (w_wrap) r_duty <= m3powerI;
    end
  end

  logic       w_idle;
  logic [1:0] w_posLeg;
  logic [1:0] w_negLeg;
  logic [2:0] w_reqHi;
  logic [2:0] w_reqLo;

  always_comb begin
    w_posLeg = 2'd0;
    w_negLeg = 2'd1;
    case (m3stepI[3:1])
      3'd0: begin w_posLeg = 2'd0; w_negLeg = 2'd1; end
      3'd1: begin w_posLeg = 2'd0; w_negLeg = 2'd2; end
      3'd2: begin w_posLeg = 2'd1; w_negLeg = 2'd2; end
      3'd3: begin w_posLeg = 2'd1; w_negLeg = 2'd0; end
      3'd4: begin w_posLeg = 2'd2; w_negLeg = 2'd0; end
      3'd5: begin w_posLeg = 2'd2; w_negLeg = 2'd1; end
      default: ;
    endcase
    w_idle  = (m3stepI > 4'd11) || m3forceStopI;
    w_reqHi = (w_idle || !w_pwmOn) ? 3'b000 : phase_mask(w_posLeg, m3invRotateI);
    w_reqLo = w_idle ? 3'b000 : phase_mask(w_negLeg, m3invRotateI);
  end

  leg_state_t r_state [3];
  logic [3:0] r_dead  [3];
  logic [2:0] r_ho;
  logic [2:0] r_lo;
  logic       r_active;
  logic [2:0] w_legOnNext;

  // Look-ahead of each leg's gate so the activity flag lands on the same edge as the gates.
  always_comb begin
    w_legOnNext = '0;
    for (int i = 0; i < 3; i++) begin
      w_legOnNext[i] = ((r_state[i] == LEG_OFF) && (w_reqHi[i] || w_reqLo[i])) ||
                       ((r_state[i] == LEG_HI)  && w_reqHi[i]) ||
                       ((r_state[i] == LEG_LO)  && w_reqLo[i]);
    end
  end

  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      for (int i = 0; i < 3; i++) begin
        r_state[i] <= LEG_OFF;
        r_dead[i]  <= 4'd0;
      end
      r_ho     <= '0;
      r_lo     <= '0;
      r_active <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        case (r_state[i])
          LEG_OFF: begin
            if (w_reqHi[i]) begin
              r_state[i] <= LEG_HI;
              r_ho[i]    <= 1'b1;
            end else if (w_reqLo[i]) begin
              r_state[i] <= LEG_LO;
              r_lo[i]    <= 1'b1;
            end
          end
          LEG_HI: begin
            if (!w_reqHi[i]) begin
              r_state[i] <= LEG_DEAD;
              r_dead[i]  <= DEAD_INIT;
              r_ho[i]    <= 1'b0;
            end
          end
          LEG_LO: begin
            if (!w_reqLo[i]) begin
              r_state[i] <= LEG_DEAD;
              r_dead[i]  <= DEAD_INIT;
              r_lo[i]    <= 1'b0;
            end
          end
          default: begin
            r_ho[i] <= 1'b0;
            r_lo[i] <= 1'b0;
            if (r_dead[i] == 4'd0) r_state[i] <= LEG_OFF;
            else                   r_dead[i]  <= r_dead[i] - 1'b1;
          end
        endcase
      end
      r_active <= |w_legOnNext;
    end
  end

  assign m3uHo     = r_ho[0];
  assign m3uLo     = r_lo[0];
  assign m3vHo     = r_ho[1];
  assign m3vLo     = r_lo[1];
  assign m3wHo     = r_ho[2];
  assign m3wLo     = r_lo[2];
  assign m3activeO = r_active;

endmodule

// File: tb/tb_m3_phasegatedriver.sv
`timescale 1ns/1ps
// Bench for m3_phasegatedriver: cycle model feeds a scoreboard queue, plus directed duty,
// sector, dead-time, force-stop and async-reset checks.
module tb_m3_phasegatedriver;
  localparam int PWM_BITS  = 8;
  localparam int DEAD_CLKS = 2;
  localparam int PERIOD    = 256;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] step = 4'hF;
  logic [7:0] power = 8'd0;
  logic       inv = 1'b0;
  logic       fstop = 1'b0;
  logic       uHo, uLo, vHo, vLo, wHo, wLo, active;

  int n_chk = 0;
  int n_err = 0;
  logic [6:0] sb_q [$];

  int m_cnt, m_duty;
  int m_mode [3];
  int m_gap  [3];
  int mon_gap [3];
  logic [2:0] mon_prev;

  int POS_TAB [6] = '{0, 0, 1, 1, 2, 2};
  int NEG_TAB [6] = '{1, 2, 2, 0, 0, 1};
  logic [5:0] FWD_TAB [6] = '{6'b100100, 6'b100001, 6'b001001, 6'b011000, 6'b010010, 6'b000110};
  logic [5:0] INV_TAB [6] = '{6'b100001, 6'b100100, 6'b000110, 6'b010010, 6'b011000, 6'b001001};

  always #5 clk = ~clk;

  m3_phasegatedriver #(.PWM_BITS(PWM_BITS), .DEAD_CLKS(DEAD_CLKS)) dut (
    .clkI(clk), .nRstI(rst_n), .m3stepI(step), .m3powerI(power),
    .m3invRotateI(inv), .m3forceStopI(fstop),
    .m3uHo(uHo), .m3uLo(uLo), .m3vHo(vHo), .m3vLo(vLo), .m3wHo(wHo), .m3wLo(wLo),
    .m3activeO(active)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] gates();
    return {uHo, uLo, vHo, vLo, wHo, wLo};
  endfunction

  function automatic int swap_vw(input int leg);
    return (leg == 1) ? 2 : ((leg == 2) ? 1 : leg);
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_duty = 0;
    for (int i = 0; i < 3; i++) begin
      m_mode[i]  = 0;
      m_gap[i]   = 99;
      mon_gap[i] = 99;
    end
    mon_prev = 3'b000;
  endtask

  // One clock: advance the model, queue its prediction, then compare after the edge.
  task automatic tick();
    int req [3];
    int s, p, n;
    logic [6:0] e;
    logic [6:0] g;
    logic [2:0] on;
    req = '{0, 0, 0};
    if (int'(step) < 12 && !fstop) begin
      s = int'(step) >> 1;
      p = POS_TAB[s];
      n = NEG_TAB[s];
      if (inv) begin
        p = swap_vw(p);
        n = swap_vw(n);
      end
      req[n] = 2;
      if (m_cnt < m_duty) req[p] = 1;
    end
    for (int i = 0; i < 3; i++) begin
      if (m_mode[i] != 0) begin
        if (req[i] != m_mode[i]) begin
          m_mode[i] = 0;
          m_gap[i]  = 1;
        end
      end else if (req[i] != 0 && m_gap[i] >= DEAD_CLKS + 1) begin
        m_mode[i] = req[i];
      end else if (m_gap[i] < 99) begin
        m_gap[i]++;
      end
    end
    if (m_cnt == PERIOD - 1) m_duty = int'(power);
    m_cnt = (m_cnt + 1) % PERIOD;
    e = {m_mode[0] == 1, m_mode[0] == 2, m_mode[1] == 1, m_mode[1] == 2,
         m_mode[2] == 1, m_mode[2] == 2, 1'b0};
    e[0] = |e[6:1];
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    g = {gates(), active};
    chk("gates", 32'(g), 32'(sb_q.pop_front()));
    chk("shoot_through", 32'({uHo & uLo, vHo & vLo, wHo & wLo}), 32'd0);
    on = {wHo | wLo, vHo | vLo, uHo | uLo};
    for (int i = 0; i < 3; i++) begin
      if (on[i] && !mon_prev[i]) chk("gap_min", 32'(mon_gap[i] >= DEAD_CLKS + 1), 32'd1);
      if (on[i]) mon_gap[i] = 0;
      else if (mon_gap[i] < 99) mon_gap[i]++;
    end
    mon_prev = on;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int h, hv, hw;
    logic [5:0] acc;
    model_reset();
    power = 8'd128;
    #23;
    chk("reset_outputs", 32'({gates(), active}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle step: nothing may ever drive.
    acc = '0;
    h = 0;
    repeat (1000) begin
      tick();
      acc |= gates();
      h += int'(active);
    end
    chk("idle_gates", 32'(acc), 32'd0);
    chk("idle_active", 32'(h), 32'd0);

    // Step 0 forward at duty 64, then a mid-carrier duty change.
    step = 4'd0;
    power = 8'd64;
    repeat (600) tick();
    h = 0; hv = 0; hw = 0;
    repeat (PERIOD) begin
      tick();
      h  += int'(uHo);
      hv += int'(vLo);
      hw += int'(wHo) + int'(wLo);
    end
    chk("duty64_uHo", 32'(h), 32'd64);
    chk("duty64_vLo", 32'(hv), 32'(PERIOD));
    chk("duty64_w", 32'(hw), 32'd0);
    while (m_cnt != 128) tick();
    power = 8'd192;
    h = 0;
    while (m_cnt != 0) begin
      tick();
      h += int'(uHo);
    end
    chk("duty_stale", 32'(h), 32'd0);
    h = 0;
    repeat (PERIOD) begin
      tick();
      h += int'(uHo);
    end
    chk("duty192_uHo", 32'(h), 32'd192);

    // Sector walk, forward then reverse.
    power = 8'd128;
    for (int d = 0; d < 2; d++) begin
      for (int st = 0; st < 12; st++) begin
        step = 4'(st);
        inv = (d == 1);
        repeat (44) tick();
        acc = '0;
        repeat (PERIOD) begin
          tick();
          acc |= gates();
        end
        chk(d == 0 ? "sector_fwd" : "sector_inv", 32'(acc),
            32'(d == 0 ? FWD_TAB[st / 2] : INV_TAB[st / 2]));
      end
    end

    // Full duty: the single off clock stretches to the dead-time minimum.
    step = 4'd2;
    inv = 1'b0;
    power = 8'd255;
    repeat (600) tick();
    h = 0; hw = 0;
    repeat (PERIOD) begin
      tick();
      h  += int'(uHo);
      hw += int'(wLo);
    end
    chk("duty255_uHo", 32'(h), 32'(PERIOD - (DEAD_CLKS + 1)));
    chk("duty255_wLo", 32'(hw), 32'(PERIOD));

    // Force stop pulse, then restart through dead time.
    step = 4'd6;
    power = 8'd128;
    repeat (600) tick();
    chk("pre_stop_uLo", 32'(uLo), 32'd1);
    fstop = 1'b1;
    tick();
    fstop = 1'b0;
    chk("fstop_off", 32'({gates(), active}), 32'd0);
    tick();
    chk("fstop_dead1_u", 32'({uHo, uLo}), 32'd0);
    tick();
    chk("fstop_dead2_u", 32'({uHo, uLo}), 32'd0);
    tick();
    chk("fstop_restart_uLo", 32'(uLo), 32'd1);
    chk("fstop_restart_act", 32'(active), 32'd1);

    // Asynchronous reset pulse mid-carrier.
    repeat ($urandom_range(10, 300)) tick();
    rst_n = 1'b0;
    #2;
    chk("async_reset", 32'({gates(), active}), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    chk("reset_held", 32'({gates(), active}), 32'd0);
    rst_n = 1'b1;
    repeat (600) tick();

    // Random soak.
    repeat (20000) begin
      if ($urandom_range(0, 31) == 0) step = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 63) == 0) inv = 1'($urandom);
      power = 8'($urandom);
      fstop = ($urandom_range(0, 63) == 0);
      tick();
    end

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
